// File: rtl/row_write_scheduler_pkg.sv
// Shared parameters, lane map and FSM encoding for the row write scheduler.
// Lane of a colour plane is disp*3 + colour.
package row_write_scheduler_pkg;

  localparam int COLOR_BITS    = 8;
  localparam int ROW_ADDR_BITS = 6;
  localparam int COL_ADDR_BITS = 4;
  localparam int DISP_COUNT    = 2;

  localparam int NREQ   = 2;
  localparam int PIXELS = 1 << ROW_ADDR_BITS;
  localparam int ROW_W  = PIXELS * COLOR_BITS;
  localparam int RGB_W  = 3 * COLOR_BITS;
  localparam int LANES  = DISP_COUNT * 3;
  localparam int DISP_W = (DISP_COUNT > 1) ? $clog2(DISP_COUNT) : 1;

  localparam int LANE_R = 0;
  localparam int LANE_G = 1;
  localparam int LANE_B = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    FILL,
    HOLD,
    COMMIT
  } state_t;

  // Empty mask means the display index has no RAM behind it.
  function automatic logic [LANES-1:0] lane_mask(
    input logic [DISP_W-1:0] disp
  );
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < DISP_COUNT; i++) begin
      if (disp == DISP_W'(i)) begin
        m[i*3+LANE_R] = 1'b1;
        m[i*3+LANE_G] = 1'b1;
        m[i*3+LANE_B] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic disp_ok(
    input logic [DISP_W-1:0] disp
  );
    return |lane_mask(disp);
  endfunction

endpackage

// File: rtl/row_write_scheduler_if.sv
// Requester streams in, per-colour RAM write port out.
// master = requesters + RAM side, slave = scheduler.
interface row_write_scheduler_if;
  import row_write_scheduler_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*DISP_W-1:0] req_disp;
  logic [NREQ*COL_ADDR_BITS-1:0] req_row;
  logic [NREQ*RGB_W-1:0]  req_rgb;

  logic [LANES-1:0]         wr_en;
  logic [COL_ADDR_BITS-1:0] wr_addr;
  logic [ROW_W-1:0]         wr_data_r;
  logic [ROW_W-1:0]         wr_data_g;
  logic [ROW_W-1:0]         wr_data_b;
  logic [NREQ-1:0]          row_done;

  modport master (
    output req_valid, req_last, req_disp,
    output req_row, req_rgb,
    input  req_ready, wr_en, wr_addr,
    input  wr_data_r, wr_data_g, wr_data_b,
    input  row_done
  );

  modport slave (
    input  req_valid, req_last, req_disp,
    input  req_row, req_rgb,
    output req_ready, wr_en, wr_addr,
    output wr_data_r, wr_data_g, wr_data_b,
    output row_done
  );

endinterface

// File: rtl/row_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the grant is decided combinationally
// and last_grant advances only when the caller takes the decision.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       take,
  output logic       grant,
  output logic       any
);

  logic last_grant;

  assign any = |valid;

  always_comb begin
    grant = last_grant;
    unique case (1'b1)
      (valid == 2'b01): grant = 1'b0;
      (valid == 2'b10): grant = 1'b1;
      (valid == 2'b11): grant = ~last_grant;
      default:          grant = last_grant;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (take && any) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/row_write_scheduler.sv
// Per-row arbitration, RGB row assembly and scan-safe commit
// into the per-colour pixel RAM write ports.
module row_write_scheduler
  import row_write_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  row_write_scheduler_if.slave     bus,
  input  logic [COL_ADDR_BITS-1:0] scan_row,
  output logic                     proto_err
);

  state_t                   state;
  logic [ROW_ADDR_BITS-1:0] beat_cnt;
  logic                     gnt;
  logic [DISP_W-1:0]        disp_q;
  logic [COL_ADDR_BITS-1:0] row_q;
  logic [ROW_W-1:0]         buf_r;
  logic [ROW_W-1:0]         buf_g;
  logic [ROW_W-1:0]         buf_b;

  logic                     arb_take;
  logic                     arb_grant;
  logic                     arb_any;
  logic [DISP_W-1:0]        arb_disp;
  logic [COL_ADDR_BITS-1:0] arb_row;

  logic                     sel_valid;
  logic                     sel_last;
  logic [RGB_W-1:0]         sel_rgb;
  logic                     accept;
  logic                     cnt_end;
  int                       pix_lsb;

  assign arb_take = (state == ARB);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.req_valid),
    .take  (arb_take),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign arb_disp  = bus.req_disp[int'(arb_grant)*DISP_W +: DISP_W];
  assign arb_row   =
    bus.req_row[int'(arb_grant)*COL_ADDR_BITS +: COL_ADDR_BITS];

  assign sel_valid = bus.req_valid[gnt];
  assign sel_last  = bus.req_last[gnt];
  assign sel_rgb   = bus.req_rgb[int'(gnt)*RGB_W +: RGB_W];
  assign accept    = sel_valid && bus.req_ready[gnt];
  assign cnt_end   = &beat_cnt;
  assign pix_lsb   = int'(beat_cnt) * COLOR_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      gnt           <= 1'b0;
      disp_q        <= '0;
      row_q         <= '0;
      buf_r         <= '0;
      buf_g         <= '0;
      buf_b         <= '0;
      proto_err     <= 1'b0;
      bus.req_ready <= '0;
      bus.wr_en     <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data_r <= '0;
      bus.wr_data_g <= '0;
      bus.wr_data_b <= '0;
      bus.row_done  <= '0;
    end else begin
      bus.wr_en    <= '0;
      bus.row_done <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) state <= ARB;
        end
        ARB: begin
          if (arb_any) begin
            gnt           <= arb_grant;
            disp_q        <= arb_disp;
            row_q         <= arb_row;
            beat_cnt      <= '0;
            bus.req_ready <= NREQ'(1) << arb_grant;
            if (!disp_ok(arb_disp)) proto_err <= 1'b1;
            state         <= FILL;
          end else begin
            state <= IDLE;
          end
        end
        FILL: begin
          if (accept) begin
            buf_r[pix_lsb +: COLOR_BITS] <=
              sel_rgb[2*COLOR_BITS +: COLOR_BITS];
            buf_g[pix_lsb +: COLOR_BITS] <=
              sel_rgb[COLOR_BITS +: COLOR_BITS];
            buf_b[pix_lsb +: COLOR_BITS] <=
              sel_rgb[0 +: COLOR_BITS];
            beat_cnt <= beat_cnt + ROW_ADDR_BITS'(1);
            // Final pixel closes the row even if last was not flagged.
            if (cnt_end) begin
              if (!sel_last) proto_err <= 1'b1;
              bus.req_ready <= '0;
              state         <= HOLD;
            end else if (sel_last) begin
              proto_err     <= 1'b1;
              bus.req_ready <= '0;
              state         <= IDLE;
            end
          end
        end
        HOLD: begin
          // Never overwrite the row the scan path is displaying.
          if (scan_row != row_q) begin
            bus.wr_en     <= lane_mask(disp_q);
            bus.wr_addr   <= row_q;
            bus.wr_data_r <= buf_r;
            bus.wr_data_g <= buf_g;
            bus.wr_data_b <= buf_b;
            bus.row_done  <= NREQ'(1) << gnt;
            state         <= COMMIT;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_write_scheduler.sv
// Scoreboard bench for row_write_scheduler: drivers push expected
// commits, a negedge monitor pops and compares each RAM write.
module tb_row_write_scheduler;
  import row_write_scheduler_pkg::*;

  typedef struct {
    logic [5:0]   en;
    logic [3:0]   addr;
    logic [511:0] r;
    logic [511:0] g;
    logic [511:0] b;
    logic [1:0]   done;
    int           mode;
    int           req;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] scan_row = 4'd15;
  logic proto_err;

  logic       v[2];
  logic       lst[2];
  logic       dv[2];
  logic [3:0] rw[2];
  logic [23:0] rgb[2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc[2];
  int release_cyc = -1000;
  exp_t sbq[$];
  exp_t me;

  row_write_scheduler_if bus ();

  assign bus.req_valid = {v[1], v[0]};
  assign bus.req_last  = {lst[1], lst[0]};
  assign bus.req_disp  = {dv[1], dv[0]};
  assign bus.req_row   = {rw[1], rw[0]};
  assign bus.req_rgb   = {rgb[1], rgb[0]};

  row_write_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .scan_row  (scan_row),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input logic [7:0] seed,
                                      input int p);
    logic [7:0] pb;
    pb = p[7:0];
    return {pb ^ seed, ~pb, 8'hA5 ^ seed};
  endfunction

  function automatic exp_t mk(input int k, input logic dsp,
                              input logic [3:0] row,
                              input logic [7:0] seed, input int mode);
    exp_t e;
    logic [23:0] px;
    e.en   = dsp ? 6'b111000 : 6'b000111;
    e.addr = row;
    e.done = (k == 0) ? 2'b01 : 2'b10;
    e.mode = mode;
    e.req  = k;
    e.r = '0;
    e.g = '0;
    e.b = '0;
    for (int p = 0; p < 64; p++) begin
      px = pix(seed, p);
      e.r[p*8 +: 8] = px[23:16];
      e.g[p*8 +: 8] = px[15:8];
      e.b[p*8 +: 8] = px[7:0];
    end
    return e;
  endfunction

  // rst_at >= 0 pulls reset while that beat is being presented.
  task automatic send(input int k, input logic dsp, input logic [3:0] row,
                      input logic [7:0] seed, input int last_at,
                      input int stall_at, input int stall_len,
                      input int rst_at);
    int b = 0;
    int st = 0;
    int guard = 0;
    logic acc;
    dv[k] = dsp;
    rw[k] = row;
    while (b <= last_at && guard < 1000) begin
      guard++;
      if (b == rst_at) begin
        v[k] = 1'b0;
        lst[k] = 1'b0;
        rst_n = 1'b0;
        return;
      end
      if (b == stall_at && st < stall_len) begin
        v[k] = 1'b0;
        st++;
        @(posedge clk);
        #1;
        continue;
      end
      v[k] = 1'b1;
      rgb[k] = pix(seed, b);
      lst[k] = (b == last_at);
      @(negedge clk);
      acc = bus.req_ready[k];
      if (acc && lst[k]) last_cyc[k] = cyc;
      @(posedge clk);
      #1;
      if (acc) b++;
    end
    v[k] = 1'b0;
    lst[k] = 1'b0;
    total++;
    if (b <= last_at) begin
      bad++;
      $display("FAIL send_timeout req=%0d act=%0d beats exp=%0d",
               k, b, last_at + 1);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_data_r"}, bus.wr_data_r, 0);
    chk({tag, "_data_g"}, bus.wr_data_g, 0);
    chk({tag, "_data_b"}, bus.wr_data_b, 0);
    chk({tag, "_row_done"}, bus.row_done, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.wr_en != 0 || bus.row_done != 0)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write act_en=%b act_done=%b exp=none",
                 bus.wr_en, bus.row_done);
      end else begin
        me = sbq.pop_front();
        chk("wr_en", bus.wr_en, me.en);
        chk("wr_addr", bus.wr_addr, me.addr);
        chk("row_done", bus.row_done, me.done);
        chk("data_r", bus.wr_data_r, me.r);
        chk("data_g", bus.wr_data_g, me.g);
        chk("data_b", bus.wr_data_b, me.b);
        if (me.mode == 1)
          chk("latency", cyc - last_cyc[me.req], 2);
        else if (me.mode == 2)
          chk("hold_release", cyc - release_cyc, 1);
      end
    end
  end

  initial begin
    int w;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0;
      lst[k] = 1'b0;
      dv[k] = 1'b0;
      rw[k] = 4'd0;
      rgb[k] = 24'd0;
      last_cyc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Contention from reset: req0, req1, then req0 again.
    sbq.push_back(mk(0, 1'b0, 4'd1, 8'h11, 1));
    sbq.push_back(mk(1, 1'b1, 4'd2, 8'h22, 1));
    fork
      send(0, 1'b0, 4'd1, 8'h11, 63, -1, 0, -1);
      send(1, 1'b1, 4'd2, 8'h22, 63, -1, 0, -1);
    join
    sbq.push_back(mk(0, 1'b1, 4'd6, 8'h33, 1));
    sbq.push_back(mk(1, 1'b0, 4'd8, 8'h44, 1));
    fork
      send(0, 1'b1, 4'd6, 8'h33, 63, -1, 0, -1);
      send(1, 1'b0, 4'd8, 8'h44, 63, -1, 0, -1);
    join
    repeat (5) @(posedge clk);
    #1;

    // Basic row: R byte of pixel p equals p.
    scan_row = 4'd0;
    sbq.push_back(mk(0, 1'b0, 4'd5, 8'h00, 1));
    send(0, 1'b0, 4'd5, 8'h00, 63, -1, 0, -1);
    repeat (5) @(posedge clk);
    #1;

    // Row conflict with the scan path.
    scan_row = 4'd3;
    sbq.push_back(mk(1, 1'b1, 4'd3, 8'h5C, 2));
    send(1, 1'b1, 4'd3, 8'h5C, 63, -1, 0, -1);
    repeat (40) @(posedge clk);
    #1;
    release_cyc = cyc;
    scan_row = 4'd4;
    repeat (5) @(posedge clk);
    #1;
    chk("err_before_short", proto_err, 0);

    // Short row: last on beat 10.
    send(0, 1'b0, 4'd10, 8'h66, 10, -1, 0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("short_row_err", proto_err, 1);
    sbq.push_back(mk(1, 1'b1, 4'd7, 8'h3C, 1));
    send(1, 1'b1, 4'd7, 8'h3C, 63, -1, 0, -1);
    repeat (5) @(posedge clk);
    #1;

    // Valid stall mid-row.
    sbq.push_back(mk(0, 1'b0, 4'd9, 8'h5A, 1));
    send(0, 1'b0, 4'd9, 8'h5A, 63, 30, 7, -1);
    repeat (6) @(posedge clk);
    #1;

    // Reset during beat 20, then a clean row.
    send(0, 1'b0, 4'd10, 8'h99, 63, -1, 0, 20);
    #1;
    check_idle("midrow_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sbq.push_back(mk(0, 1'b1, 4'd12, 8'h77, 1));
    send(0, 1'b1, 4'd12, 8'h77, 63, -1, 0, -1);

    w = 0;
    while (sbq.size() > 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
